// File: rtl/autocorr_delay_mult.sv
// Delay-and-multiply stage of the autocorrelation front end.
// One signed sample is taken on every clock. Two clocks after a sample
// x(k) is captured, the output is x(k) * x(k-DELAY) at full 2*WIDTH precision.
//
// Pipeline:
//   edge k   : in_q  <= x(k)
//   edge k+1 : cur_q <= x(k); dly_q <= history slot (x(k-DELAY)); the slot <= x(k)
//   edge k+2 : delay_mult_out <= cur_q * dly_q
//
// The pointer advances on every edge after reset. This includes edge 0,
// when in_q still holds its cleared zero. As a result, the slot written at
// edge j always holds x(j-1), and the slot read at edge k+1 was last written
// at edge k+1-DELAY, i.e. it holds x(k-DELAY).
module autocorr_delay_mult #(
  parameter int WIDTH = 16,
  parameter int DELAY = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [WIDTH-1:0]   sample_in,
  output logic signed [2*WIDTH-1:0] delay_mult_out,
  output logic                      delay_mult_valid
);

  localparam int PTR_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int FILL_MAX = DELAY + 2;
  localparam int CNT_W    = $clog2(FILL_MAX + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILL_MAX);

  logic signed [WIDTH-1:0]   in_q;
  logic signed [WIDTH-1:0]   cur_q;
  logic signed [WIDTH-1:0]   dly_q;
  logic signed [WIDTH-1:0]   hist_q [DELAY];
  logic [PTR_W-1:0]          ptr_q;
  logic [PTR_W-1:0]          ptr_d;
  logic [CNT_W-1:0]          fill_q;
  logic [CNT_W-1:0]          fill_d;
  logic signed [2*WIDTH-1:0] prod_d;
  logic signed [2*WIDTH-1:0] out_q;
  logic                      valid_q;
  logic                      valid_d;

  // Next-state terms: wrapping history pointer, saturating fill counter, product.
  // The fill counter equals the number of edges since reset until it saturates
  // at DELAY+2. That is the first edge whose product uses two genuine samples.
  always_comb begin
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    prod_d  = '0;
    if (ptr_q == PTR_LAST) begin
      ptr_d = '0;
    end else begin
      ptr_d = ptr_q + 1'b1;
    end
    if (fill_q == CNT_FULL) begin
      valid_d = 1'b1;
    end else begin
      fill_d = fill_q + 1'b1;
    end
    prod_d = cur_q * dly_q;
  end

  // Pipeline and history registers. A synchronous reset clears every entry so
  // that no pre-reset sample can reach the multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q    <= '0;
      cur_q   <= '0;
      dly_q   <= '0;
      ptr_q   <= '0;
      fill_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DELAY; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      in_q          <= sample_in;
      cur_q         <= in_q;
      dly_q         <= hist_q[ptr_q];
      hist_q[ptr_q] <= in_q;
      ptr_q         <= ptr_d;
      fill_q        <= fill_d;
      out_q         <= prod_d;
      valid_q       <= valid_d;
    end
  end

  assign delay_mult_out   = out_q;
  assign delay_mult_valid = valid_q;

endmodule

// File: tb/tb_autocorr_delay_mult.sv
// Bench for autocorr_delay_mult: three instances (DELAY=32/W=16, DELAY=7/W=16,
// DELAY=1/W=8) share one stimulus stream. Each is compared every cycle against
// a sample-history model: out after edge e = x(e-2) * x(e-2-DELAY), where
// x(j) = 0 for j < 0, and valid = (e-2 >= DELAY).
module tb_autocorr_delay_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample_in;

  logic signed [31:0] out32, out7;
  logic signed [15:0] out1;
  logic               val32, val7, val1;

  int vectors = 0;
  int miscompares = 0;

  // Samples captured since the last reset edge, as driven (16 bits).
  logic [15:0] xs[$];

  always #5 clk = ~clk;

  autocorr_delay_mult #(.WIDTH(16), .DELAY(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
    .delay_mult_out(out32), .delay_mult_valid(val32));

  autocorr_delay_mult #(.WIDTH(16), .DELAY(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
    .delay_mult_out(out7), .delay_mult_valid(val7));

  autocorr_delay_mult #(.WIDTH(8), .DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in[7:0]),
    .delay_mult_out(out1), .delay_mult_valid(val1));

  function automatic longint xv(int idx, int w);
    logic [15:0] v;
    logic [7:0]  b;
    if (idx < 0) return 0;
    v = xs[idx];
    b = v[7:0];
    if (w == 8) return longint'($signed(b));
    return longint'($signed(v));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int d, input int w,
                         input longint obs, input logic vld);
    int     k;
    longint e;
    k = xs.size() - 3;
    e = xv(k, w) * xv(k - d, w);
    chk({tag, "_out"}, obs, e);
    chk({tag, "_valid"}, longint'(vld), longint'(k >= d));
  endtask

  task automatic tick(input logic rst_v, input logic [15:0] s);
    rst_n     = rst_v;
    sample_in = s;
    @(posedge clk);
    #1;
    if (!rst_v) xs.delete();
    else xs.push_back(s);
    vectors++;
    chk_dut("d32", 32, 16, longint'(out32), val32);
    chk_dut("d7", 7, 16, longint'(out7), val7);
    chk_dut("d1", 1, 8, longint'(out1), val1);
  endtask

  initial begin
    logic [15:0] s;
    rst_n = 1'b0;
    sample_in = '0;

    // Reset state.
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h5a5a);
    chk("rst_out32", longint'(out32), 0);
    chk("rst_val32", longint'(val32), 0);

    // Ramp, then a mid-stream reset, then the ramp again.
    for (int k = 0; k <= 50; k++) begin
      s = 16'h1337 + 16'(k * 16'h0101);
      tick(1'b1, s);
      if (k == 33) chk("ramp_e33_val", longint'(val32), 0);
      if (k == 34) begin
        chk("ramp_e34_out", longint'(out32), 64650417);
        chk("ramp_e34_val", longint'(val32), 1);
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 16'hffff);
    chk("midrst_out", longint'(out32), 0);
    chk("midrst_val", longint'(val32), 0);
    for (int k = 0; k < 300; k++) begin
      s = 16'h1337 + 16'(k * 16'h0101);
      tick(1'b1, s);
      if (k == 33) chk("rerun_e33_out", longint'(out32), 0);
    end

    // Sign extremes.
    tick(1'b0, 16'h0);
    for (int k = 0; k < 40; k++) tick(1'b1, 16'h8000);
    chk("min_sq", longint'(out32), 64'h40000000);
    tick(1'b0, 16'h0);
    for (int k = 0; k < 96; k++) tick(1'b1, (k / 32 == 1) ? 16'h7fff : 16'h8000);
    chk("min_x_max", longint'(out32), -64'sd1073709056);
    for (int k = 0; k < 40; k++) tick(1'b1, (k % 3 == 0) ? 16'h0 : 16'h8000);

    // Impulse.
    tick(1'b0, 16'h0);
    for (int k = 0; k < 140; k++) begin
      s = (k == 5) ? 16'h0002 : ((k == 100 || k == 132) ? 16'h0003 : 16'h0000);
      tick(1'b1, s);
      if (k == 134) chk("imp_e134", longint'(out32), 9);
      if (k == 135) chk("imp_e135", longint'(out32), 0);
    end

    // Lag 1 on the 8-bit instance.
    tick(1'b0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 16'(k + 1));
      if (k == 2) begin
        chk("lag1_e2_val", longint'(val1), 0);
      end
      if (k == 3) begin
        chk("lag1_e3", longint'(out1), 2);
        chk("lag1_e3_val", longint'(val1), 1);
      end
      if (k == 4) chk("lag1_e4", longint'(out1), 6);
      if (k == 5) chk("lag1_e5", longint'(out1), 12);
    end

    // Random samples with occasional reset pulses.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        for (int r = 0; r < int'($urandom_range(1, 3)); r++) tick(1'b0, 16'($urandom));
      end
      tick(1'b1, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
